// File: rtl/fpu_sqrt_wb_collect_pkg.sv
// ---------------------------------------------------------------------------
// fpu_sqrt_wb_collect_pkg
// Shared types and width constants for the sqrt/div writeback collector.
//   wb_entry_t : one buffered result (lane enables, instruction index, opcode,
//                destination/status registers, write enable, data halves).
// ---------------------------------------------------------------------------
package fpu_sqrt_wb_collect_pkg;

    localparam int EN_W    = 4;
    localparam int II_W    = 10;
    localparam int OP_W    = 13;
    localparam int REG_W   = 9;
    localparam int DATAF_W = 84;
    localparam int DATAV_W = 68;

    typedef struct packed {
        logic [EN_W-1:0]    en;
        logic [II_W-1:0]    ii;
        logic [OP_W-1:0]    op;
        logic [REG_W-1:0]   dst_reg;
        logic [REG_W-1:0]   sreg;
        logic               wen;
        logic [DATAF_W-1:0] data_f;
        logic [DATAV_W-1:0] data_v;
    } wb_entry_t;

    localparam int ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/fpu_sqrt_wb_collect_fifo.sv
// ---------------------------------------------------------------------------
// fpu_wb_fifo
// Circular buffer of wb_entry_t results with flush.
//   clk, rst      : clock, asynchronous active-low reset
//   flush         : empties the buffer next cycle; push/pop that cycle ignored
//   push/push_data: write one entry (dropped when full unless a pop frees it)
//   pop/pop_data  : pop_data is the head, valid whenever empty=0
//   full, empty   : status from the registered count
//   count         : current number of entries
// ---------------------------------------------------------------------------
module fpu_wb_fifo
    import fpu_sqrt_wb_collect_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  wb_entry_t              push_data,
    input  logic                   pop,
    output wb_entry_t              pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == DEPTH_C);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty && !flush;
        // A pop in the same cycle frees the slot the push lands in.
        do_push  = push && !flush && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: rtl/fpu_sqrt_wb_collect.sv
// ---------------------------------------------------------------------------
// fpu_sqrt_wb_collect
// Collects sqrt/div results into a small FIFO and writes them back through
// the alternate register-file port whenever the primary writeback leaves the
// port free (slot_busy=0).
//   clk, rst          : clock, asynchronous active-low reset
//   except            : pipeline flush (drops queue and pending writeback)
//   in_*              : incoming result; any nonzero in_en is a push
//   slot_busy         : primary writeback owns the port next cycle
//   pause             : back-pressure, all bits = (occ >= PAUSE_LVL)
//   alten             : copy of wb_en
//   wb_*              : registered writeback, wb_en valid for one cycle
//   occ               : FIFO occupancy
//   ovf               : sticky overflow (push while full, no pop)
// Build option: define FPU_SQRT_WB_BYPASS_EN to send a result straight to the
// wb_ registers when the FIFO is empty and the port is free.
// ---------------------------------------------------------------------------
module fpu_sqrt_wb_collect
    import fpu_sqrt_wb_collect_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int PAUSE_LVL = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   except,
    input  logic [EN_W-1:0]        in_en,
    input  logic [II_W-1:0]        in_II,
    input  logic [OP_W-1:0]        in_op,
    input  logic [REG_W-1:0]       in_reg,
    input  logic [REG_W-1:0]       in_sreg,
    input  logic                   in_wen,
    input  logic [DATAF_W-1:0]     in_dataF,
    input  logic [DATAV_W-1:0]     in_dataV,
    input  logic                   slot_busy,
    output logic [EN_W-1:0]        pause,
    output logic [EN_W-1:0]        alten,
    output logic [EN_W-1:0]        wb_en,
    output logic [II_W-1:0]        wb_II,
    output logic [OP_W-1:0]        wb_op,
    output logic [REG_W-1:0]       wb_reg,
    output logic [REG_W-1:0]       wb_sreg,
    output logic                   wb_wen,
    output logic [DATAF_W-1:0]     wb_dataF,
    output logic [DATAV_W-1:0]     wb_dataV,
    output logic [$clog2(DEPTH):0] occ,
    output logic                   ovf
);

    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam logic [OCC_W-1:0] PAUSE_THR = OCC_W'(PAUSE_LVL);

    wb_entry_t        in_entry;
    wb_entry_t        head;
    wb_entry_t        wb_q, wb_d;
    logic             ovf_q, ovf_d;
    logic             push_req;
    logic             pop_req;
    logic             bypass;
    logic             fifo_push;
    logic             fifo_full;
    logic             fifo_empty;
    logic [OCC_W-1:0] count;

    always_comb begin
        in_entry         = '0;
        in_entry.en      = in_en;
        in_entry.ii      = in_II;
        in_entry.op      = in_op;
        in_entry.dst_reg = in_reg;
        in_entry.sreg    = in_sreg;
        in_entry.wen     = in_wen;
        in_entry.data_f  = in_dataF;
        in_entry.data_v  = in_dataV;
    end

    always_comb begin
        push_req = (in_en != '0) && !except;
        pop_req  = !slot_busy && !fifo_empty && !except;
`ifdef FPU_SQRT_WB_BYPASS_EN
        bypass   = push_req && fifo_empty && !slot_busy;
`else
        bypass   = 1'b0;
`endif
        fifo_push = push_req && !bypass;
        // Full with no pop: the FIFO drops the entry, we only flag it.
        ovf_d     = ovf_q | (fifo_push && fifo_full && !pop_req);

        // Non-enable fields hold when nothing is written back.
        wb_d    = wb_q;
        wb_d.en = '0;
        if (pop_req) begin
            wb_d = head;
        end else if (bypass) begin
            wb_d = in_entry;
        end
    end

    fpu_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (except),
        .push      (fifo_push),
        .push_data (in_entry),
        .pop       (pop_req),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            wb_q  <= wb_d;
            ovf_q <= ovf_d;
        end
    end

    assign wb_en    = wb_q.en;
    assign alten    = wb_q.en;
    assign wb_II    = wb_q.ii;
    assign wb_op    = wb_q.op;
    assign wb_reg   = wb_q.dst_reg;
    assign wb_sreg  = wb_q.sreg;
    assign wb_wen   = wb_q.wen;
    assign wb_dataF = wb_q.data_f;
    assign wb_dataV = wb_q.data_v;
    assign occ      = count;
    assign ovf      = ovf_q;
    // Registered count only, so pause has no combinational input path.
    assign pause    = {EN_W{count >= PAUSE_THR}};

endmodule

// File: tb/tb_fpu_sqrt_wb_collect.sv
`timescale 1ns/1ps
module tb_fpu_sqrt_wb_collect;
    import fpu_sqrt_wb_collect_pkg::*;

    localparam int DEPTH     = 4;
    localparam int PAUSE_LVL = 3;
    localparam int OCC_W     = 3;

    // ---------------- clock / reset / DUT ----------------
    logic               clk = 1'b0;
    logic               rst;
    logic               except;
    logic [EN_W-1:0]    in_en;
    logic [II_W-1:0]    in_II;
    logic [OP_W-1:0]    in_op;
    logic [REG_W-1:0]   in_reg;
    logic [REG_W-1:0]   in_sreg;
    logic               in_wen;
    logic [DATAF_W-1:0] in_dataF;
    logic [DATAV_W-1:0] in_dataV;
    logic               slot_busy;
    logic [EN_W-1:0]    pause;
    logic [EN_W-1:0]    alten;
    logic [EN_W-1:0]    wb_en;
    logic [II_W-1:0]    wb_II;
    logic [OP_W-1:0]    wb_op;
    logic [REG_W-1:0]   wb_reg;
    logic [REG_W-1:0]   wb_sreg;
    logic               wb_wen;
    logic [DATAF_W-1:0] wb_dataF;
    logic [DATAV_W-1:0] wb_dataV;
    logic [OCC_W-1:0]   occ;
    logic               ovf;

    always #5 clk = ~clk;

    fpu_sqrt_wb_collect #(
        .DEPTH     (DEPTH),
        .PAUSE_LVL (PAUSE_LVL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .except    (except),
        .in_en     (in_en),
        .in_II     (in_II),
        .in_op     (in_op),
        .in_reg    (in_reg),
        .in_sreg   (in_sreg),
        .in_wen    (in_wen),
        .in_dataF  (in_dataF),
        .in_dataV  (in_dataV),
        .slot_busy (slot_busy),
        .pause     (pause),
        .alten     (alten),
        .wb_en     (wb_en),
        .wb_II     (wb_II),
        .wb_op     (wb_op),
        .wb_reg    (wb_reg),
        .wb_sreg   (wb_sreg),
        .wb_wen    (wb_wen),
        .wb_dataF  (wb_dataF),
        .wb_dataV  (wb_dataV),
        .occ       (occ),
        .ovf       (ovf)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a plain queue of pending results plus the last writeback.
    logic [ENTRY_W-1:0] exp_q[$];
    wb_entry_t          exp_wb  = '0;
    logic               exp_ovf = 1'b0;
    wb_entry_t          m_in;
    logic               m_has_in;
    logic               m_pop;
    logic               m_byp;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q.delete();
            exp_wb  = '0;
            exp_ovf = 1'b0;
        end else begin
            m_in = '{en: in_en, ii: in_II, op: in_op, dst_reg: in_reg, sreg: in_sreg,
                     wen: in_wen, data_f: in_dataF, data_v: in_dataV};
            m_has_in = (in_en != 4'h0);
            if (except) begin
                exp_q.delete();
                exp_wb.en = 4'h0;
            end else begin
                m_pop = !slot_busy && (exp_q.size() > 0);
                m_byp = 1'b0;
`ifdef FPU_SQRT_WB_BYPASS_EN
                m_byp = m_has_in && (exp_q.size() == 0) && !slot_busy;
`endif
                if (m_pop) exp_wb = exp_q.pop_front();
                else if (m_byp) exp_wb = m_in;
                else exp_wb.en = 4'h0;
                if (m_has_in && !m_byp) begin
                    if (exp_q.size() < DEPTH) exp_q.push_back(m_in);
                    else exp_ovf = 1'b1;
                end
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        check("wb_en",    wb_en,    exp_wb.en);
        check("alten",    alten,    exp_wb.en);
        check("wb_II",    wb_II,    exp_wb.ii);
        check("wb_op",    wb_op,    exp_wb.op);
        check("wb_reg",   wb_reg,   exp_wb.dst_reg);
        check("wb_sreg",  wb_sreg,  exp_wb.sreg);
        check("wb_wen",   wb_wen,   exp_wb.wen);
        check("wb_dataF", wb_dataF, exp_wb.data_f);
        check("wb_dataV", wb_dataV, exp_wb.data_v);
        check("occ",      occ,      exp_q.size());
        check("pause",    pause,    (exp_q.size() >= PAUSE_LVL) ? 4'hF : 4'h0);
        check("ovf",      ovf,      exp_ovf);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [EN_W-1:0] en, input logic [II_W-1:0] ii);
        logic [95:0] r;
        in_en    = en;
        in_II    = ii;
        in_op    = OP_W'($urandom());
        in_reg   = REG_W'($urandom());
        in_sreg  = REG_W'($urandom());
        in_wen   = 1'($urandom());
        r        = {$urandom(), $urandom(), $urandom()};
        in_dataF = r[DATAF_W-1:0];
        r        = {$urandom(), $urandom(), $urandom()};
        in_dataV = r[DATAV_W-1:0];
    endtask

    task automatic idle();
        in_en = 4'h0;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        idle();
        except    = 1'b0;
        slot_busy = 1'b0;
        tick();
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        rst       = 1'b0;
        except    = 1'b0;
        slot_busy = 1'b0;
        drive(4'h0, 10'h0);
        repeat (2) tick();
        check("rst_wb_en", wb_en, 4'h0);
        check("rst_occ",   occ,   3'd0);
        check("rst_pause", pause, 4'h0);
        check("rst_ovf",   ovf,   1'b0);
        check("rst_wb_II", wb_II, 10'h0);
        rst = 1'b1;

        // Single result.
        drive(4'h3, 10'h05A);
        in_reg = 9'h021;
        tick();
        idle();
`ifdef FPU_SQRT_WB_BYPASS_EN
        check("t1_byp_en", wb_en, 4'h3);
        check("t1_byp_ii", wb_II, 10'h05A);
        check("t1_byp_rg", wb_reg, 9'h021);
`else
        check("t1_lat1_en", wb_en, 4'h0);
        check("t1_lat1_occ", occ, 3'd1);
        tick();
        check("t1_en", wb_en, 4'h3);
        check("t1_ii", wb_II, 10'h05A);
        check("t1_rg", wb_reg, 9'h021);
`endif
        check("t1_occ", occ, 3'd0);
        tick();
        check("t1_en_drop", wb_en, 4'h0);

        // Stall with three queued, then drain.
        slot_busy = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive(4'h1, 10'(i));
            tick();
        end
        idle();
        check("t2_occ", occ, 3'd3);
        check("t2_pause", pause, 4'hF);
        slot_busy = 1'b0;
        tick();
        check("t2_ii1", wb_II, 10'd1);
        check("t2_pause_clr", pause, 4'h0);
        tick();
        check("t2_ii2", wb_II, 10'd2);
        tick();
        check("t2_ii3", wb_II, 10'd3);
        check("t2_occ0", occ, 3'd0);

        // Overflow on the fifth push.
        pulse_reset();
        slot_busy = 1'b1;
        for (int i = 11; i <= 15; i++) begin
            drive(4'hF, 10'(i));
            tick();
        end
        idle();
        check("t3_ovf", ovf, 1'b1);
        check("t3_occ", occ, 3'd4);
        slot_busy = 1'b0;
        for (int i = 11; i <= 14; i++) begin
            tick();
            check("t3_drain", wb_II, 10'(i));
        end
        tick();
        check("t3_no5th", wb_en, 4'h0);

        // Full with simultaneous push and pop.
        pulse_reset();
        slot_busy = 1'b1;
        for (int i = 21; i <= 24; i++) begin
            drive(4'h2, 10'(i));
            tick();
        end
        slot_busy = 1'b0;
        drive(4'h2, 10'd25);
        tick();
        idle();
        check("t4_ii21", wb_II, 10'd21);
        check("t4_occ", occ, 3'd4);
        check("t4_ovf", ovf, 1'b0);
        for (int i = 22; i <= 25; i++) begin
            tick();
            check("t4_drain", wb_II, 10'(i));
        end

        // Flush with two queued plus a push.
        tick();
        slot_busy = 1'b1;
        drive(4'h4, 10'd31);
        tick();
        drive(4'h4, 10'd32);
        tick();
        except    = 1'b1;
        slot_busy = 1'b0;
        drive(4'h4, 10'd33);
        tick();
        except = 1'b0;
        idle();
        check("t5_occ", occ, 3'd0);
        check("t5_en", wb_en, 4'h0);
        check("t5_pause", pause, 4'h0);
        tick();
        check("t5_stale", wb_en, 4'h0);

        // Asynchronous reset mid-drain.
        slot_busy = 1'b1;
        for (int i = 41; i <= 43; i++) begin
            drive(4'h8, 10'(i));
            tick();
        end
        idle();
        slot_busy = 1'b0;
        tick();
        check("t6_ii41", wb_II, 10'd41);
        rst = 1'b0;
        #2;
        check("t6_en", wb_en, 4'h0);
        check("t6_alten", alten, 4'h0);
        check("t6_ii", wb_II, 10'h0);
        check("t6_dataF", wb_dataF, 84'h0);
        check("t6_occ", occ, 3'd0);
        check("t6_pause", pause, 4'h0);
        check("t6_wen", wb_wen, 1'b0);
        #1;
        rst = 1'b1;
        drive(4'h5, 10'd44);
        tick();
        idle();
`ifndef FPU_SQRT_WB_BYPASS_EN
        tick();
`endif
        check("t6_after_en", wb_en, 4'h5);
        check("t6_after_ii", wb_II, 10'd44);

        // Random traffic with busy-heavy and busy-light windows.
        for (int blk = 0; blk < 20; blk++) begin
            int busy_pct;
            busy_pct = $urandom_range(0, 90);
            if (blk == 10) pulse_reset();
            for (int c = 0; c < 100; c++) begin
                if ($urandom_range(0, 2) == 0) drive(4'h0, 10'($urandom()));
                else drive(4'($urandom_range(1, 15)), 10'($urandom()));
                slot_busy = ($urandom_range(0, 99) < busy_pct);
                except    = ($urandom_range(0, 49) == 0);
                tick();
            end
        end
        idle();
        except    = 1'b0;
        slot_busy = 1'b0;
        repeat (DEPTH + 2) tick();
        check("final_occ", occ, 3'd0);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_sqrt_wb_collect.md
FPU_SQRT_WB_COLLECT -- requirements
Module: fpu_sqrt_wb_collect

Interface
REQ-001 Parameter DEPTH, default 4: result FIFO entries (power of two, at least 4).
REQ-002 Parameter PAUSE_LVL, default 3: occupancy at or above which pause is raised.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-low; all state is reset while rst=0.
REQ-005 except  in  1  pipeline flush.
REQ-006 in_en  in  4  per-lane result valid from the sqrt/div unit; any nonzero value means push.
REQ-007 in_II  in  10  instruction index.
REQ-008 in_op  in  13  operation code.
REQ-009 in_reg  in  9  destination register.
REQ-010 in_sreg  in  9  status destination register.
REQ-011 in_wen  in  1  register write enable.
REQ-012 in_dataF  in  84  scalar/low result {16 ext bits, 68 data bits}.
REQ-013 in_dataV  in  68  vector-high result.
REQ-014 slot_busy  in  1  primary writeback owns the register-file port next cycle.
REQ-015 pause  out  4  back-pressure to the sqrt unit (its fxFRT_pause), all bits equal.
REQ-016 alten  out  4  copy of wb_en; marks an alternate-port write (its fxFRT_alten).
REQ-017 wb_en, wb_II, wb_op, wb_reg, wb_sreg, wb_wen, wb_dataF, wb_dataV  out  same widths as the in_ fields  registered writeback.
REQ-018 occ  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-019 ovf  out  1  sticky overflow flag.

Function
REQ-020 Push: when in_en!=0 and except=0, all in_ fields SHALL be written as one FIFO entry.
REQ-021 Pop: when slot_busy=0 and the FIFO is non-empty at cycle N, the head SHALL be loaded into the wb_ registers and SHALL be visible at N+1 for exactly one cycle.
REQ-022 When no pop occurs, wb_en SHALL be 0 the next cycle. Other wb_ fields SHALL hold their previous values.
REQ-023 An entry pushed at cycle N SHALL be poppable no earlier than N+1. Without bypass, the minimum latency from in_en to wb_en is 2 cycles.
REQ-024 Entries SHALL leave in push order. Read and write pointers SHALL wrap modulo DEPTH.
REQ-025 A simultaneous push and pop SHALL leave occ unchanged. This SHALL hold when the FIFO is full.
REQ-026 A push while full with no pop SHALL discard the incoming entry, keep the FIFO contents, and set ovf until reset.
REQ-027 pause SHALL equal {4{occ>=PAUSE_LVL}}, derived from the occ register only, with no input-to-output combinational path.
REQ-028 When except=1 at cycle N, the following SHALL apply at N+1: FIFO empty, occ=0, wb_en=0, pause=0. A push or pop in cycle N SHALL be ignored. ovf SHALL be kept.
REQ-029 slot_busy held at 1 SHALL stall pops indefinitely without losing entries.

Reset
REQ-030 While rst=0: pointers=0, occ=0, ovf=0, wb_en=0, alten=0, pause=0, wb_wen=0.
REQ-031 While rst=0: every other wb_ field SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL discard all entries immediately.
REQ-033 The first push SHALL be accepted on the first rising edge after rst rises.

Configuration
REQ-034 Macro FPU_SQRT_WB_BYPASS_EN enables the bypass path.
REQ-035 With the macro defined: if the FIFO is empty, slot_busy=0, except=0 and in_en!=0 at N, the input SHALL go directly to the wb_ registers (valid at N+1) and SHALL NOT be written into the FIFO.
REQ-036 Without the macro: every result passes through the FIFO (REQ-023 latency).

Structure
REQ-037 A shared package SHALL hold the entry struct (en, II, op, reg, sreg, wen, dataF, dataV) and the width constants II_W=10, OP_W=13, REG_W=9, DATAF_W=84, DATAV_W=68.
REQ-038 A single sub-module fpu_wb_fifo (parameterised DEPTH, storing the package struct, exposing push/pop/full/empty/count/flush) SHALL hold the storage. Arbitration and output registers stay in the top module.

Verification
REQ-039 Single push, slot_busy=0, with in_II=10'h05A and in_reg=9'h021 -> wb_en=in_en at +2 cycles with matching fields (+1 cycle with the bypass macro); occ returns to 0.
REQ-040 slot_busy=1 while pushing 3 results -> occ=3 and pause=4'hF; after releasing slot_busy, results drain in order on 3 consecutive cycles and pause clears once occ<3.
REQ-041 Fill to 4 entries, then push again with slot_busy=1 -> ovf=1, the fifth result is never written back, and the first four drain intact.
REQ-042 Full FIFO with a simultaneous push and pop -> occ stays 4 and the pushed entry emerges fifth.
REQ-043 except pulsed with 2 entries queued plus a push in the same cycle -> next cycle occ=0 and wb_en=0; no stale writeback follows.
REQ-044 rst driven low mid-drain -> all outputs zero asynchronously, and a push after release emerges normally.
